reset_sequencer: RTL and testbench

Generates the sequenced reset tree for the SoC from the PLL lock indication and external reset sources. Runs on the system clock and sits directly behind the clock generator, turning its lock output, the board reset button, and a software reset request into ordered, glitch-free releases of three reset domains: memory controller, core system, peripherals. It records the cause of the last reset for software.

---
 rtl/reset_pkg.sv | 26 ++
 rtl/debounce_filter.sv | 41 ++++
 rtl/reset_sequencer.sv | 174 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_pkg.sv
// Shared types for the SoC reset sequencer: reset-cause encoding and sequencer states.
package reset_pkg;

  typedef enum logic [1:0] {
    POWER_ON  = 2'd0,
    LOCK_LOSS = 2'd1,
    BUTTON    = 2'd2,
    SOFTWARE  = 2'd3
  } reset_cause_t;

  typedef enum logic [2:0] {
    StHold,
    StWaitLock,
    StLockStable,
    StWaitCalib,
    StSysGap,
    StPeriphGap,
    StRun
  } rstseq_state_t;

  // States in which a drop of the synchronized lock counts as a lock-loss event.
  function automatic logic past_lock_stable(input rstseq_state_t s);
    return (s == StWaitCalib) || (s == StSysGap) || (s == StPeriphGap) || (s == StRun);
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer followed by a stability filter: the output follows the
// synchronized input only after CYCLES consecutive differing samples.
module debounce_filter #(
  parameter int unsigned CYCLES = 16384
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o
);

  localparam int unsigned CntW = $clog2(CYCLES + 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= async_i;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CntW'(CYCLES - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign level_o = r_level;

endmodule

// File: rtl/reset_sequencer.sv
// Sequenced SoC reset tree: waits for stable PLL lock, releases memory, core and
// peripheral resets in order, and records the cause of the last reset.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned DEBOUNCE_CYCLES    = 16384,
  parameter int unsigned RELEASE_GAP        = 16,
  parameter int unsigned CALIB_TIMEOUT      = 1048576
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       button_rst_i,
  input  logic       soft_rst_i,
  input  logic       mem_calib_done_i,
  output logic       mem_rst_o,
  output logic       sys_rst_o,
  output logic       periph_rst_o,
  output logic [1:0] reset_cause_o,
  output logic       calib_timeout_o
);

  localparam int unsigned LockW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned CalW  = $clog2(CALIB_TIMEOUT + 1);
  localparam int unsigned GapW  = $clog2(RELEASE_GAP + 1);

  logic r_lock_s1, r_lock_s2, r_cal_s1, r_cal_s2;
  logic w_lock, w_calib, w_button;

  rstseq_state_t    r_state, w_state_next;
  logic [LockW-1:0] r_lock_cnt, w_lock_cnt_next;
  logic [CalW-1:0]  r_cal_cnt, w_cal_cnt_next;
  logic [GapW-1:0]  r_gap_cnt, w_gap_cnt_next;
  logic             r_mem_rst, r_sys_rst, r_periph_rst, r_calib_to;
  logic             w_mem_rst_next, w_sys_rst_next, w_periph_rst_next, w_calib_to_next;
  reset_cause_t     r_cause, w_cause_next;

  debounce_filter #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_button_debounce (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(button_rst_i),
    .level_o(w_button)
  );

  assign w_lock  = r_lock_s2;
  assign w_calib = r_cal_s2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock_s1    <= 1'b0;
      r_lock_s2    <= 1'b0;
      r_cal_s1     <= 1'b0;
      r_cal_s2     <= 1'b0;
      r_state      <= StHold;
      r_lock_cnt   <= '0;
      r_cal_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_mem_rst    <= 1'b1;
      r_sys_rst    <= 1'b1;
      r_periph_rst <= 1'b1;
      r_calib_to   <= 1'b0;
      r_cause      <= POWER_ON;
    end else begin
      r_lock_s1    <= pll_locked_i;
      r_lock_s2    <= r_lock_s1;
      r_cal_s1     <= mem_calib_done_i;
      r_cal_s2     <= r_cal_s1;
      r_state      <= w_state_next;
      r_lock_cnt   <= w_lock_cnt_next;
      r_cal_cnt    <= w_cal_cnt_next;
      r_gap_cnt    <= w_gap_cnt_next;
      r_mem_rst    <= w_mem_rst_next;
      r_sys_rst    <= w_sys_rst_next;
      r_periph_rst <= w_periph_rst_next;
      r_calib_to   <= w_calib_to_next;
      r_cause      <= w_cause_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_lock_cnt_next   = r_lock_cnt;
    w_cal_cnt_next    = r_cal_cnt;
    w_gap_cnt_next    = r_gap_cnt;
    w_mem_rst_next    = r_mem_rst;
    w_sys_rst_next    = r_sys_rst;
    w_periph_rst_next = r_periph_rst;
    w_calib_to_next   = r_calib_to;
    w_cause_next      = r_cause;

    if ((past_lock_stable(r_state) && !w_lock) || (r_state != StHold && w_button)) begin
      w_state_next      = StHold;
      w_lock_cnt_next   = '0;
      w_cal_cnt_next    = '0;
      w_gap_cnt_next    = '0;
      w_mem_rst_next    = 1'b1;
      w_sys_rst_next    = 1'b1;
      w_periph_rst_next = 1'b1;
      // Lock loss outranks the button when both are seen together.
      w_cause_next      = (past_lock_stable(r_state) && !w_lock) ? LOCK_LOSS : BUTTON;
    end else begin
      unique case (r_state)
        StHold: begin
          if (!w_button) w_state_next = StWaitLock;
        end
        StWaitLock: begin
          if (w_lock) begin
            w_state_next    = StLockStable;
            w_lock_cnt_next = '0;
          end
        end
        StLockStable: begin
          if (!w_lock) begin
            w_state_next    = StWaitLock;
            w_lock_cnt_next = '0;
          end else if (r_lock_cnt == LockW'(LOCK_STABLE_CYCLES)) begin
            w_state_next   = StWaitCalib;
            w_mem_rst_next = 1'b0;
            w_cal_cnt_next = '0;
          end else begin
            w_lock_cnt_next = r_lock_cnt + LockW'(1);
          end
        end
        StWaitCalib: begin
          if (w_calib || r_cal_cnt == CalW'(CALIB_TIMEOUT - 1)) begin
            w_state_next    = StSysGap;
            w_gap_cnt_next  = '0;
            w_calib_to_next = r_calib_to | ~w_calib;
          end else begin
            w_cal_cnt_next = r_cal_cnt + CalW'(1);
          end
        end
        StSysGap: begin
          if (r_gap_cnt == GapW'(RELEASE_GAP)) begin
            w_state_next   = StPeriphGap;
            w_sys_rst_next = 1'b0;
            // The release cycle itself counts toward the peripheral gap.
            w_gap_cnt_next = GapW'(1);
          end else begin
            w_gap_cnt_next = r_gap_cnt + GapW'(1);
          end
        end
        StPeriphGap: begin
          if (r_gap_cnt == GapW'(RELEASE_GAP)) begin
            w_state_next      = StRun;
            w_periph_rst_next = 1'b0;
          end else begin
            w_gap_cnt_next = r_gap_cnt + GapW'(1);
          end
        end
        StRun: begin
          if (soft_rst_i) begin
            w_state_next      = StSysGap;
            w_gap_cnt_next    = '0;
            w_sys_rst_next    = 1'b1;
            w_periph_rst_next = 1'b1;
            w_cause_next      = SOFTWARE;
          end
        end
        default: w_state_next = StHold;
      endcase
    end
  end

  assign mem_rst_o       = r_mem_rst;
  assign sys_rst_o       = r_sys_rst;
  assign periph_rst_o    = r_periph_rst;
  assign reset_cause_o   = r_cause;
  assign calib_timeout_o = r_calib_to;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus a randomized phase,
// all compared every cycle against a deadline-based reference model.
module tb_reset_sequencer;

  localparam int LockN = 8;
  localparam int DebN  = 4;
  localparam int GapN  = 2;
  localparam int CalN  = 16;

  localparam int MHold = 0, MWaitLock = 1, MLockRun = 2, MCalib = 3;
  localparam int MSysGap = 4, MPeriphGap = 5, MRun = 6;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       pll_locked_i = 1'b0;
  logic       button_rst_i = 1'b0;
  logic       soft_rst_i = 1'b0;
  logic       mem_calib_done_i = 1'b0;
  logic       mem_rst_o, sys_rst_o, periph_rst_o, calib_timeout_o;
  logic [1:0] reset_cause_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state.
  int   m_phase = MHold;
  int   m_deadline = 0;
  int   m_cause = 0;
  bit   m_mem = 1, m_sys = 1, m_per = 1, m_to = 0;
  bit   m_lk1 = 0, m_lk2 = 0, m_cal1 = 0, m_cal2 = 0, m_bt1 = 0, m_bt2 = 0, m_db = 0;
  bit   m_win[$];

  reset_sequencer #(
    .LOCK_STABLE_CYCLES(LockN),
    .DEBOUNCE_CYCLES   (DebN),
    .RELEASE_GAP       (GapN),
    .CALIB_TIMEOUT     (CalN)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pll_locked_i    (pll_locked_i),
    .button_rst_i    (button_rst_i),
    .soft_rst_i      (soft_rst_i),
    .mem_calib_done_i(mem_calib_done_i),
    .mem_rst_o       (mem_rst_o),
    .sys_rst_o       (sys_rst_o),
    .periph_rst_o    (periph_rst_o),
    .reset_cause_o   (reset_cause_o),
    .calib_timeout_o (calib_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [5:0] dut_vec();
    return {mem_rst_o, sys_rst_o, periph_rst_o, reset_cause_o, calib_timeout_o};
  endfunction

  // Evaluates one clock edge of the reference model using the inputs present at the edge.
  task automatic model_step();
    bit lk, cal, bt, all_diff;
    lk  = m_lk2;
    cal = m_cal2;
    bt  = m_db;
    if (rst_i) begin
      m_phase = MHold;
      {m_mem, m_sys, m_per} = 3'b111;
      m_cause = 0;
      m_to    = 0;
    end else if (!lk && m_phase >= MCalib) begin
      m_phase = MHold;
      {m_mem, m_sys, m_per} = 3'b111;
      m_cause = 1;
    end else if (bt && m_phase != MHold) begin
      m_phase = MHold;
      {m_mem, m_sys, m_per} = 3'b111;
      m_cause = 2;
    end else begin
      case (m_phase)
        MHold: if (!bt) m_phase = MWaitLock;
        MWaitLock: if (lk) begin
          m_phase    = MLockRun;
          m_deadline = cyc + LockN + 1;
        end
        MLockRun: begin
          if (!lk) m_phase = MWaitLock;
          else if (cyc == m_deadline) begin
            m_phase    = MCalib;
            m_mem      = 0;
            m_deadline = cyc + CalN;
          end
        end
        MCalib: if (cal || cyc == m_deadline) begin
          if (!cal) m_to = 1;
          m_phase    = MSysGap;
          m_deadline = cyc + GapN + 1;
        end
        MSysGap: if (cyc == m_deadline) begin
          m_sys      = 0;
          m_phase    = MPeriphGap;
          m_deadline = cyc + GapN;
        end
        MPeriphGap: if (cyc == m_deadline) begin
          m_per   = 0;
          m_phase = MRun;
        end
        MRun: if (soft_rst_i) begin
          m_sys      = 1;
          m_per      = 1;
          m_cause    = 3;
          m_phase    = MSysGap;
          m_deadline = cyc + GapN + 1;
        end
        default: ;
      endcase
    end
    if (rst_i) begin
      {m_lk1, m_lk2, m_cal1, m_cal2, m_bt1, m_bt2, m_db} = 7'b0;
      m_win.delete();
    end else begin
      m_win.push_back(m_bt2);
      if (m_win.size() > DebN) void'(m_win.pop_front());
      all_diff = (m_win.size() == DebN);
      foreach (m_win[k]) if (m_win[k] == m_db) all_diff = 0;
      if (all_diff) m_db = ~m_db;
      m_lk2  = m_lk1;
      m_lk1  = pll_locked_i;
      m_cal2 = m_cal1;
      m_cal1 = mem_calib_done_i;
      m_bt2  = m_bt1;
      m_bt1  = button_rst_i;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    cyc++;
    model_step();
    #1;
    check("model", dut_vec(), {m_mem, m_sys, m_per, 2'(m_cause), m_to});
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_periph_release(input string tag);
    int k = 0;
    while (periph_rst_o !== 1'b0 && k < 300) begin
      tick();
      k++;
    end
    check(tag, {5'd0, periph_rst_o}, 6'd0);
  endtask

  initial begin
    int s, r, g, rp, w, btn_left;

    // Power-up: rst_i on edges 1..3, lock sampled high from edge 5, calib from edge 20.
    tick();
    check("reset_state", dut_vec(), 6'b111_00_0);
    run_to(3);
    rst_i = 1'b0;
    run_to(4);
    pll_locked_i = 1'b1;
    run_to(15);
    check("pwr_mem_held", {5'd0, mem_rst_o}, 6'd1);
    tick();
    check("pwr_mem_fall16", {5'd0, mem_rst_o}, 6'd0);
    run_to(19);
    mem_calib_done_i = 1'b1;
    run_to(24);
    check("pwr_sys_held", {5'd0, sys_rst_o}, 6'd1);
    tick();
    check("pwr_sys_fall25", {5'd0, sys_rst_o}, 6'd0);
    tick();
    check("pwr_periph_held", {5'd0, periph_rst_o}, 6'd1);
    tick();
    check("pwr_periph_fall27", {4'd0, periph_rst_o, calib_timeout_o}, 6'd0);
    check("pwr_cause", {4'd0, reset_cause_o}, 6'd0);
    repeat (3) tick();

    // Soft reset in RUN.
    soft_rst_i = 1'b1;
    tick();
    soft_rst_i = 1'b0;
    s = cyc;
    check("soft_assert", {1'b0, mem_rst_o, sys_rst_o, periph_rst_o, reset_cause_o}, 6'b0_011_11);
    run_to(s + 2);
    check("soft_sys_held", {5'd0, sys_rst_o}, 6'd1);
    tick();
    check("soft_sys_fall", {5'd0, sys_rst_o}, 6'd0);
    tick();
    check("soft_periph_held", {5'd0, periph_rst_o}, 6'd1);
    tick();
    check("soft_periph_fall", {4'd0, mem_rst_o, periph_rst_o}, 6'd0);

    // Button bounce: short pulses must not reset anything.
    repeat (4) begin
      button_rst_i = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      button_rst_i = 1'b0;
      repeat ($urandom_range(2, 6)) tick();
    end
    repeat (8) tick();
    check("bounce_no_reset", {3'd0, mem_rst_o, sys_rst_o, periph_rst_o}, 6'd0);

    // Button held 10 cycles in RUN.
    button_rst_i = 1'b1;
    s = cyc;
    run_to(s + 6);
    check("btn_not_yet", {5'd0, periph_rst_o}, 6'd0);
    tick();
    check("btn_assert", {1'b0, mem_rst_o, sys_rst_o, periph_rst_o, reset_cause_o}, 6'b0_111_10);
    run_to(s + 10);
    button_rst_i = 1'b0;
    wait_periph_release("btn_restart");

    // Lock loss in RUN, relock with a one-cycle glitch during the stability count.
    repeat ($urandom_range(1, 5)) tick();
    pll_locked_i = 1'b0;
    s = cyc;
    run_to(s + 2);
    check("lockloss_not_yet", {5'd0, mem_rst_o}, 6'd0);
    tick();
    check("lockloss_assert", {1'b0, mem_rst_o, sys_rst_o, periph_rst_o, reset_cause_o}, 6'b0_111_01);
    repeat ($urandom_range(2, 6)) tick();
    pll_locked_i = 1'b1;
    r = cyc + 1;
    g = $urandom_range(1, 5);
    run_to(r + g - 1);
    pll_locked_i = 1'b0;
    tick();
    pll_locked_i = 1'b1;
    rp = cyc + 1;
    run_to(rp + 10);
    check("glitch_mem_held", {5'd0, mem_rst_o}, 6'd1);
    tick();
    check("glitch_mem_fall", {5'd0, mem_rst_o}, 6'd0);
    wait_periph_release("relock_run");

    // rst_i mid-sequence, then calibration never completes.
    mem_calib_done_i = 1'b0;
    button_rst_i = 1'b1;
    repeat (12) tick();
    button_rst_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_mid", dut_vec(), 6'b111_00_0);
    w = 0;
    while (mem_rst_o !== 1'b0 && w < 100) begin
      tick();
      w++;
    end
    check("calib_mem_fall", {5'd0, mem_rst_o}, 6'd0);
    w = cyc;
    run_to(w + 15);
    check("calib_to_not_yet", {5'd0, calib_timeout_o}, 6'd0);
    tick();
    check("calib_to_set", {5'd0, calib_timeout_o}, 6'd1);
    wait_periph_release("calib_to_run");
    soft_rst_i = 1'b1;
    tick();
    soft_rst_i = 1'b0;
    repeat (8) tick();
    check("calib_to_persist", {4'd0, periph_rst_o, calib_timeout_o}, 6'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_clears_to", {5'd0, calib_timeout_o}, 6'd0);

    // Randomized phase against the model.
    mem_calib_done_i = 1'b1;
    btn_left = 0;
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 399));
      if (r < 3) pll_locked_i = 1'b0;
      else if (r < 60) pll_locked_i = 1'b1;
      if (btn_left > 0) begin
        btn_left--;
        button_rst_i = 1'b1;
      end else begin
        button_rst_i = 1'b0;
        if (r >= 60 && r < 66) btn_left = int'($urandom_range(1, 12));
      end
      if (r == 100) mem_calib_done_i = ~mem_calib_done_i;
      soft_rst_i = (r >= 370) ? 1'b1 : 1'b0;
      rst_i = (r == 399) ? 1'b1 : 1'b0;
      tick();
    end
    rst_i = 1'b0;
    soft_rst_i = 1'b0;
    button_rst_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
